// File: rtl/stream_tuple_unpacker.sv
// stream_tuple_unpacker
//   Splits wide AXI4-Stream beats from the read master into fixed-width tuples,
//   one tuple per cycle, for the join stage. A job is started with a tuple
//   count; the unpacker consumes exactly ceil(count/LANES) beats, drops the
//   padding lanes of the final beat, marks the final tuple with tlast and
//   pulses ctrl_done once the job completes.
//
// Ports
//   aclk, aresetn      clock, asynchronous active-low reset
//   ctrl_start         one-cycle pulse, starts a job (ignored while busy)
//   ctrl_num_tuples    tuple count, sampled with ctrl_start
//   ctrl_done          one-cycle pulse at job end
//   s_axis_*           input beat stream (tlast is not used)
//   m_axis_*           output tuple stream, tlast on the job's final tuple
module stream_tuple_unpacker #(
   parameter int unsigned C_DATA_WIDTH  = 512,
   parameter int unsigned C_TUPLE_WIDTH = 64,
   parameter int unsigned C_COUNT_WIDTH = 32
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     ctrl_start,
   input  logic [C_COUNT_WIDTH-1:0] ctrl_num_tuples,
   output logic                     ctrl_done,
   input  logic                     s_axis_tvalid,
   output logic                     s_axis_tready,
   input  logic [C_DATA_WIDTH-1:0]  s_axis_tdata,
   input  logic                     s_axis_tlast,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic [C_TUPLE_WIDTH-1:0] m_axis_tdata,
   output logic                     m_axis_tlast
);

   localparam int unsigned LANES  = C_DATA_WIDTH / C_TUPLE_WIDTH;
   localparam int unsigned LANE_W = $clog2(LANES);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

   // Reject configurations the lane indexing cannot represent.
   generate
      if ((C_DATA_WIDTH % C_TUPLE_WIDTH) != 0 || LANES < 2 ||
          (LANES & (LANES - 1)) != 0) begin : g_bad_cfg
         $error("stream_tuple_unpacker: LANES must be a power of 2 >= 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                                   state;
   logic                                     hold_valid;
   logic [LANE_W-1:0]                        lane;
   logic [C_COUNT_WIDTH-1:0]                 remaining;
   logic [LANES-1:0][C_TUPLE_WIDTH-1:0]      hold;

   logic s_fire;
   logic m_fire;
   logic last_tuple;
   logic lane_wrap;
   logic unused_tlast;

   // Burst boundaries from the read master carry no meaning here.
   assign unused_tlast = s_axis_tlast;

   assign last_tuple = (remaining == C_COUNT_WIDTH'(1));
   assign lane_wrap  = (lane == LAST_LANE);

   // hold_valid is only ever set in RUN, so it alone qualifies the output.
   assign m_fire = hold_valid & m_axis_tready;

   // Accept a beat into an empty hold register, or reload it in the same
   // cycle the last lane leaves, provided the job still needs more tuples.
   assign s_axis_tready = (state == RUN) &
                          (~hold_valid | (m_fire & lane_wrap & ~last_tuple));
   assign s_fire        = s_axis_tvalid & s_axis_tready;

   // Output is a mux straight off the hold register; lane 0 holds the LSBs.
   assign m_axis_tvalid = hold_valid;
   assign m_axis_tdata  = hold[lane];
   assign m_axis_tlast  = hold_valid & last_tuple;
   assign ctrl_done     = (state == DONE);

   // Job control, hold register and lane/count tracking.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state      <= IDLE;
         hold_valid <= 1'b0;
         lane       <= '0;
         remaining  <= '0;
         hold       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (ctrl_start) begin
                  lane <= '0;
                  if (ctrl_num_tuples != '0) begin
                     remaining <= ctrl_num_tuples;
                     state     <= RUN;
                  end else begin
                     state <= DONE;
                  end
               end
            end

            RUN: begin
               if (s_fire) begin
                  hold       <= s_axis_tdata;
                  hold_valid <= 1'b1;
               end
               if (m_fire) begin
                  remaining <= remaining - C_COUNT_WIDTH'(1);
                  lane      <= lane + LANE_W'(1);
                  if (last_tuple) begin
                     // Remaining lanes of this beat are padding and are dropped.
                     hold_valid <= 1'b0;
                     lane       <= '0;
                     state      <= DONE;
                  end else if (lane_wrap && !s_fire) begin
                     hold_valid <= 1'b0;
                  end
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state      <= IDLE;
               hold_valid <= 1'b0;
            end
         endcase
      end
   end

   // A stalled tuple must not change until it is taken.
   property p_stall_stable;
      @(posedge aclk) disable iff (!aresetn)
         (m_axis_tvalid && !m_axis_tready) |=>
            (m_axis_tvalid && $stable(m_axis_tdata) && $stable(m_axis_tlast));
   endproperty
   a_stall_stable: assert property (p_stall_stable);

endmodule

// File: tb/tb_stream_tuple_unpacker.sv
// Testbench for stream_tuple_unpacker: table of jobs driven with a scoreboard
// of expected tuples, plus hand-written reset-mid-job sequence.
module tb_stream_tuple_unpacker;

   localparam int unsigned DW    = 512;
   localparam int unsigned TW    = 64;
   localparam int unsigned CW    = 32;
   localparam int unsigned LANES = DW / TW;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic          ctrl_start;
   logic [CW-1:0] ctrl_num_tuples;
   logic          ctrl_done;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic [DW-1:0] s_axis_tdata;
   logic          s_axis_tlast;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic [TW-1:0] m_axis_tdata;
   logic          m_axis_tlast;

   stream_tuple_unpacker #(
      .C_DATA_WIDTH (DW),
      .C_TUPLE_WIDTH(TW),
      .C_COUNT_WIDTH(CW)
   ) dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .ctrl_start     (ctrl_start),
      .ctrl_num_tuples(ctrl_num_tuples),
      .ctrl_done      (ctrl_done),
      .s_axis_tvalid  (s_axis_tvalid),
      .s_axis_tready  (s_axis_tready),
      .s_axis_tdata   (s_axis_tdata),
      .s_axis_tlast   (s_axis_tlast),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tlast   (m_axis_tlast)
   );

   always #5 aclk = ~aclk;

   typedef struct packed {
      logic [TW-1:0] data;
      logic          last;
   } exp_t;

   typedef struct {
      int num;
      int rpct;
      int vpct;
      int beats;
      bit mid_start;
   } job_vec_t;

   exp_t     sb[$];
   job_vec_t vecs[8];
   int       total = 0;
   int       bad   = 0;

   task automatic check(input bit ok, input string name,
                        input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Beat b of a job: lane l carries tuple base + b*LANES + l.
   function automatic logic [DW-1:0] mk_beat(input logic [63:0] base, input int b);
      logic [DW-1:0] r;
      r = '0;
      for (int l = 0; l < int'(LANES); l++)
         r[l*TW +: TW] = base + 64'(b * int'(LANES) + l);
      return r;
   endfunction

   task automatic run_job(input int num, input int rpct, input int vpct,
                          input int exp_beats, input bit mid_start,
                          input logic [63:0] base);
      int   beats = 0, pushed = 0, popped = 0, cycles = 0;
      int   first_fire = -1, last_fire = -1, tready_cyc = 0;
      bit   done_seen = 0, done_exp, prev_stall = 0, prev_last = 0;
      bit   s_fire, m_fire;
      logic [TW-1:0] prev_data = '0;
      exp_t e;

      @(negedge aclk);
      ctrl_start      = 1'b1;
      ctrl_num_tuples = CW'(num);
      s_axis_tvalid   = 1'b0;
      @(negedge aclk);
      done_exp = (num == 0);
      while (!done_seen && cycles < 2000) begin
         ctrl_start      = (mid_start && cycles == 3);
         ctrl_num_tuples = mid_start ? 32'd3 : CW'(num);
         s_axis_tvalid   = ($urandom_range(99) < vpct);
         s_axis_tdata    = mk_beat(base, beats);
         s_axis_tlast    = beats[0];
         m_axis_tready   = ($urandom_range(99) < rpct);
         #1;
         s_fire = s_axis_tvalid && s_axis_tready;
         m_fire = m_axis_tvalid && m_axis_tready;
         if (s_axis_tready) tready_cyc++;

         if (prev_stall) begin
            check(m_axis_tvalid == 1'b1, "stall_valid", 64'(m_axis_tvalid), 64'd1);
            check(m_axis_tdata == prev_data, "stall_data", m_axis_tdata, prev_data);
            check(m_axis_tlast == prev_last, "stall_last", 64'(m_axis_tlast), 64'(prev_last));
         end
         if (beats == exp_beats)
            check(s_axis_tready == 1'b0, "extra_beat_ready", 64'(s_axis_tready), 64'd0);
         check(ctrl_done == done_exp, "done_timing", 64'(ctrl_done), 64'(done_exp));
         done_exp = 1'b0;

         if (m_fire) begin
            if (sb.size() == 0) begin
               check(1'b0, "unexpected_tuple", m_axis_tdata, 64'd0);
            end else begin
               e = sb.pop_front();
               check(m_axis_tdata == e.data, "tuple_data", m_axis_tdata, e.data);
               check(m_axis_tlast == e.last, "tuple_last", 64'(m_axis_tlast), 64'(e.last));
            end
            popped++;
            if (first_fire < 0) first_fire = cycles;
            last_fire = cycles;
            if (popped == num) done_exp = 1'b1;
         end
         if (s_fire) begin
            beats++;
            for (int l = 0; l < int'(LANES); l++) begin
               if (pushed < num) begin
                  sb.push_back('{data: base + 64'(pushed), last: (pushed == num - 1)});
                  pushed++;
               end
            end
         end

         done_seen  = ctrl_done;
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_data  = m_axis_tdata;
         prev_last  = m_axis_tlast;
         cycles++;
         @(negedge aclk);
      end
      ctrl_start = 1'b0;

      check(done_seen, "job_done_timeout", 64'(done_seen), 64'd1);
      check(popped == num, "tuple_count", 64'(popped), 64'(num));
      check(beats == exp_beats, "beat_count", 64'(beats), 64'(exp_beats));
      check(sb.size() == 0, "scoreboard_empty", 64'(sb.size()), 64'd0);
      if (rpct == 100 && vpct == 100 && num > 0) begin
         check(last_fire - first_fire == num - 1, "zero_bubble",
               64'(last_fire - first_fire), 64'(num - 1));
         check(tready_cyc == exp_beats, "tready_cycles", 64'(tready_cyc), 64'(exp_beats));
      end
      sb.delete();

      // Back in IDLE: a further beat is refused and nothing is presented.
      s_axis_tvalid = 1'b1;
      #1;
      check(s_axis_tready == 1'b0, "idle_tready", 64'(s_axis_tready), 64'd0);
      check(m_axis_tvalid == 1'b0, "idle_tvalid", 64'(m_axis_tvalid), 64'd0);
      check(ctrl_done == 1'b0, "idle_done", 64'(ctrl_done), 64'd0);
      s_axis_tvalid = 1'b0;
   endtask

   initial begin
      int popped, beats;
      logic [63:0] base;

      vecs[0] = '{num: 16, rpct: 100, vpct: 100, beats: 2, mid_start: 0};
      vecs[1] = '{num: 10, rpct: 100, vpct: 100, beats: 2, mid_start: 0};
      vecs[2] = '{num: 24, rpct: 50,  vpct: 50,  beats: 3, mid_start: 0};
      vecs[3] = '{num: 0,  rpct: 100, vpct: 100, beats: 0, mid_start: 0};
      vecs[4] = '{num: 16, rpct: 100, vpct: 100, beats: 2, mid_start: 1};
      vecs[5] = '{num: 1,  rpct: 60,  vpct: 100, beats: 1, mid_start: 0};
      vecs[6] = '{num: 9,  rpct: 100, vpct: 40,  beats: 2, mid_start: 0};
      vecs[7] = '{num: 17, rpct: 70,  vpct: 80,  beats: 3, mid_start: 0};

      aresetn         = 1'b0;
      ctrl_start      = 1'b0;
      ctrl_num_tuples = '0;
      s_axis_tvalid   = 1'b0;
      s_axis_tdata    = '0;
      s_axis_tlast    = 1'b0;
      m_axis_tready   = 1'b0;

      repeat (2) @(negedge aclk);
      #1;
      check({ctrl_done, s_axis_tready, m_axis_tvalid, m_axis_tlast} == 4'b0,
            "reset_ctrl_outs", 64'({ctrl_done, s_axis_tready, m_axis_tvalid, m_axis_tlast}), 64'd0);
      check(m_axis_tdata == '0, "reset_tdata", m_axis_tdata, 64'd0);
      @(negedge aclk);
      aresetn = 1'b1;
      #1;
      check({ctrl_done, s_axis_tready, m_axis_tvalid, m_axis_tlast} == 4'b0,
            "post_reset_outs", 64'({ctrl_done, s_axis_tready, m_axis_tvalid, m_axis_tlast}), 64'd0);

      for (int i = 0; i < 8; i++)
         run_job(vecs[i].num, vecs[i].rpct, vecs[i].vpct, vecs[i].beats,
                 vecs[i].mid_start, 64'(i + 1) << 32);

      // Reset in the middle of a 16-tuple job after 5 tuples.
      base   = 64'h0000_00AA_0000_0000;
      popped = 0;
      beats  = 0;
      @(negedge aclk);
      ctrl_start      = 1'b1;
      ctrl_num_tuples = 32'd16;
      @(negedge aclk);
      ctrl_start = 1'b0;
      for (int c = 0; c < 50 && popped < 5; c++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = mk_beat(base, beats);
         m_axis_tready = 1'b1;
         #1;
         if (m_axis_tvalid && m_axis_tready) begin
            check(m_axis_tdata == base + 64'(popped), "rst_job_data",
                  m_axis_tdata, base + 64'(popped));
            popped++;
         end
         if (s_axis_tvalid && s_axis_tready) beats++;
         if (popped < 5) @(negedge aclk);
      end
      check(popped == 5, "rst_job_progress", 64'(popped), 64'd5);
      #2;
      aresetn = 1'b0;
      #1;
      check({ctrl_done, s_axis_tready, m_axis_tvalid, m_axis_tlast} == 4'b0,
            "async_reset_outs", 64'({ctrl_done, s_axis_tready, m_axis_tvalid, m_axis_tlast}), 64'd0);
      check(m_axis_tdata == '0, "async_reset_tdata", m_axis_tdata, 64'd0);
      s_axis_tvalid = 1'b0;
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         check(ctrl_done == 1'b0, "no_done_after_reset", 64'(ctrl_done), 64'd0);
         check(m_axis_tvalid == 1'b0, "no_tvalid_after_reset", 64'(m_axis_tvalid), 64'd0);
         @(negedge aclk);
      end

      run_job(8, 100, 100, 1, 1'b0, 64'h0000_00BB_0000_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
